// File: rtl/pipe_pkg.sv
// Shared types and default widths for the skid-buffered pipeline stage.
// Widths follow the EX/MEM bundle: 4 control bits, 69 payload bits.
package pipe_pkg;

  localparam int CTRL_W_DEF = 4;
  localparam int DATA_W_DEF = 69;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready handshake bundle for one pipeline stage.
// The stage itself uses the slave view; the driver uses master.
interface pipe_skid_stage_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );

endinterface

// File: rtl/pipe_slot.sv
// One pipeline register slot: valid + ctrl + data.
// Clear kills valid and ctrl but keeps the payload bits.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] ldCtrl,
  input  logic [DATA_W-1:0] ldData,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Falling-edge slot register; clear wins over load.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ldCtrl;
      data  <= ldData;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid pipeline stage with flush and stall counter.
// in_ready is registered so out_ready never reaches it combinationally.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_skid_stage_if.slave     bus,
  output logic [1:0]           occ,
  output logic [CNT_W-1:0]     stall_cnt
);

  state_e state, stateNext;

  logic rstDone;
  logic inFire, outFire;
  logic mainLoad, mainClear, mainFromSkid;
  logic skidLoad, skidClear;
  logic mainV, skidV;
  logic [CTRL_W-1:0] mainCtrl, skidCtrl, mainLdCtrl;
  logic [DATA_W-1:0] mainData, skidData, mainLdData;

  assign bus.in_ready  = rstDone && (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_ctrl  = bus.out_valid ? mainCtrl : '0;
  assign bus.out_data  = mainData;

  assign inFire  = bus.in_valid && bus.in_ready;
  assign outFire = bus.out_valid && bus.out_ready;

  assign occ = {skidV, mainV & ~skidV};

  assign mainLdCtrl = mainFromSkid ? skidCtrl : bus.in_ctrl;
  assign mainLdData = mainFromSkid ? skidData : bus.in_data;

  // Holds in_ready low until the first falling edge after reset.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) rstDone <= 1'b0;
    else     rstDone <= 1'b1;
  end

  // State register.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= stateNext;
  end

  // Next state and slot controls; flush overrides everything.
  always_comb begin
    stateNext    = state;
    mainLoad     = 1'b0;
    mainClear    = 1'b0;
    mainFromSkid = 1'b0;
    skidLoad     = 1'b0;
    skidClear    = 1'b0;
    if (flush) begin
      stateNext = EMPTY;
      mainClear = 1'b1;
      skidClear = 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (inFire) begin
            mainLoad  = 1'b1;
            stateNext = BUSY;
          end
        end
        BUSY: begin
          if (inFire && outFire) begin
            mainLoad = 1'b1;
          end else if (inFire) begin
            skidLoad  = 1'b1;
            stateNext = FULL;
          end else if (outFire) begin
            mainClear = 1'b1;
            stateNext = EMPTY;
          end
        end
        FULL: begin
          if (outFire) begin
            mainLoad     = 1'b1;
            mainFromSkid = 1'b1;
            skidClear    = 1'b1;
            stateNext    = BUSY;
          end
        end
        default: stateNext = EMPTY;
      endcase
    end
  end

  // Saturating count of back-pressured edges.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (bus.out_valid && !bus.out_ready && !flush
                 && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) uMain (
    .clk    (clk),
    .rst    (rst),
    .load   (mainLoad),
    .clear  (mainClear),
    .ldCtrl (mainLdCtrl),
    .ldData (mainLdData),
    .valid  (mainV),
    .ctrl   (mainCtrl),
    .data   (mainData)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) uSkid (
    .clk    (clk),
    .rst    (rst),
    .load   (skidLoad),
    .clear  (skidClear),
    .ldCtrl (bus.in_ctrl),
    .ldData (bus.in_data),
    .valid  (skidV),
    .ctrl   (skidCtrl),
    .data   (skidData)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage.
// Vector table plus reset, saturation and scoreboard sequences.
module tb_pipe_skid_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic flush4 = 1'b0;
  logic [1:0]  occ, occ4;
  logic [15:0] stall;
  logic [3:0]  stall4;

  int nVec = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  pipe_skid_stage_if bus ();
  pipe_skid_stage_if bus4 ();

  pipe_skid_stage dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .occ       (occ),
    .stall_cnt (stall)
  );

  pipe_skid_stage #(.CNT_W(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush4),
    .bus       (bus4),
    .occ       (occ4),
    .stall_cnt (stall4)
  );

  typedef struct {
    logic        iv;
    logic [3:0]  ic;
    logic [68:0] id;
    logic        ordy;
    logic        fl;
    logic        eV;
    logic [3:0]  eC;
    logic [68:0] eD;
    logic [1:0]  eOcc;
    logic        eIr;
    logic [15:0] eStall;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [68:0] act,
                     input logic [68:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [68:0] qd[$];
    logic [3:0]  qc[$];
    logic [68:0] curD;
    logic [3:0]  curC;
    int sent, got, cyc;

    vecs[0]  = '{1, 4'hB, 69'h01, 1, 0, 1, 4'hB, 69'h01, 2'd1, 1, 16'd0};
    vecs[1]  = '{0, 4'h0, 69'h00, 1, 0, 0, 4'h0, 69'h01, 2'd0, 1, 16'd0};
    vecs[2]  = '{1, 4'h1, 69'h10, 0, 0, 1, 4'h1, 69'h10, 2'd1, 1, 16'd0};
    vecs[3]  = '{1, 4'h2, 69'h20, 0, 0, 1, 4'h1, 69'h10, 2'd2, 0, 16'd1};
    vecs[4]  = '{1, 4'h3, 69'h30, 0, 0, 1, 4'h1, 69'h10, 2'd2, 0, 16'd2};
    vecs[5]  = '{1, 4'h3, 69'h30, 1, 0, 1, 4'h2, 69'h20, 2'd1, 1, 16'd2};
    vecs[6]  = '{1, 4'h3, 69'h30, 1, 0, 1, 4'h3, 69'h30, 2'd1, 1, 16'd2};
    vecs[7]  = '{0, 4'h0, 69'h00, 1, 0, 0, 4'h0, 69'h30, 2'd0, 1, 16'd2};
    vecs[8]  = '{1, 4'h4, 69'h40, 0, 0, 1, 4'h4, 69'h40, 2'd1, 1, 16'd2};
    vecs[9]  = '{1, 4'h5, 69'h50, 0, 0, 1, 4'h4, 69'h40, 2'd2, 0, 16'd3};
    vecs[10] = '{1, 4'h6, 69'h60, 0, 1, 0, 4'h0, 69'h40, 2'd0, 1, 16'd3};
    vecs[11] = '{0, 4'h0, 69'h00, 1, 0, 0, 4'h0, 69'h40, 2'd0, 1, 16'd3};
    vecs[12] = '{1, 4'h7, 69'h70, 1, 0, 1, 4'h7, 69'h70, 2'd1, 1, 16'd3};
    vecs[13] = '{0, 4'h0, 69'h00, 1, 0, 0, 4'h0, 69'h70, 2'd0, 1, 16'd3};

    bus.in_valid   = 1'b0;
    bus.in_ctrl    = '0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.in_ctrl   = '0;
    bus4.in_data   = '0;
    bus4.out_ready = 1'b0;

    // reset state
    @(posedge clk);
    #1;
    chk("rst.valid", 69'(bus.out_valid), 69'd0);
    chk("rst.ctrl", 69'(bus.out_ctrl), 69'd0);
    chk("rst.data", bus.out_data, 69'd0);
    chk("rst.occ", 69'(occ), 69'd0);
    chk("rst.ready", 69'(bus.in_ready), 69'd0);
    chk("rst.stall", 69'(stall), 69'd0);
    rst = 1'b0;
    @(negedge clk);
    @(posedge clk);
    chk("rst.readyAfter", 69'(bus.in_ready), 69'd1);

    // vector table
    for (int i = 0; i < 14; i++) begin
      bus.in_valid  = vecs[i].iv;
      bus.in_ctrl   = vecs[i].ic;
      bus.in_data   = vecs[i].id;
      bus.out_ready = vecs[i].ordy;
      flush         = vecs[i].fl;
      @(negedge clk);
      @(posedge clk);
      chk($sformatf("v%0d.valid", i), 69'(bus.out_valid), 69'(vecs[i].eV));
      chk($sformatf("v%0d.ctrl", i), 69'(bus.out_ctrl), 69'(vecs[i].eC));
      chk($sformatf("v%0d.data", i), bus.out_data, vecs[i].eD);
      chk($sformatf("v%0d.occ", i), 69'(occ), 69'(vecs[i].eOcc));
      chk($sformatf("v%0d.ready", i), 69'(bus.in_ready), 69'(vecs[i].eIr));
      chk($sformatf("v%0d.stall", i), 69'(stall), 69'(vecs[i].eStall));
    end
    bus.in_valid = 1'b0;
    flush = 1'b0;

    // stall counter saturation, 4-bit counter
    bus4.in_valid = 1'b1;
    bus4.in_ctrl  = 4'h9;
    bus4.in_data  = 69'h99;
    @(negedge clk);
    @(posedge clk);
    bus4.in_valid = 1'b0;
    repeat (14) @(negedge clk);
    @(posedge clk);
    chk("sat.cnt14", 69'(stall4), 69'd14);
    repeat (6) @(negedge clk);
    @(posedge clk);
    chk("sat.cnt15", 69'(stall4), 69'd15);
    repeat (5) @(negedge clk);
    @(posedge clk);
    chk("sat.hold", 69'(stall4), 69'd15);
    chk("sat.valid", 69'(bus4.out_valid), 69'd1);
    chk("sat.occ", 69'(occ4), 69'd1);

    // async reset while full
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_ctrl   = 4'hA;
    bus.in_data   = 69'h80;
    @(negedge clk);
    @(posedge clk);
    bus.in_ctrl   = 4'hC;
    bus.in_data   = 69'h90;
    @(negedge clk);
    @(posedge clk);
    bus.in_valid  = 1'b0;
    chk("ar.occBefore", 69'(occ), 69'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("ar.valid", 69'(bus.out_valid), 69'd0);
    chk("ar.ctrl", 69'(bus.out_ctrl), 69'd0);
    chk("ar.data", bus.out_data, 69'd0);
    chk("ar.occ", 69'(occ), 69'd0);
    chk("ar.stall", 69'(stall), 69'd0);
    chk("ar.stall4", 69'(stall4), 69'd0);
    chk("ar.ready", 69'(bus.in_ready), 69'd0);
    @(posedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(posedge clk);
    chk("ar.readyAfter", 69'(bus.in_ready), 69'd1);
    chk("ar.occAfter", 69'(occ), 69'd0);

    // random streaming scoreboard
    sent = 0;
    got  = 0;
    cyc  = 0;
    curD = {$urandom, $urandom, 5'($urandom)};
    curC = 4'($urandom);
    while ((sent < 100 || got < 100) && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      bus.in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
      bus.in_ctrl   = curC;
      bus.in_data   = curD;
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (!bus.out_valid)
        chk("sb.bubble", 69'(bus.out_ctrl), 69'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (qd.size() == 0) begin
          nVec++;
          nErr++;
          $display("FAIL sb.extra: got 'h%0h, want none", bus.out_data);
        end else begin
          chk($sformatf("sb.data%0d", got), bus.out_data, qd.pop_front());
          chk($sformatf("sb.ctrl%0d", got), 69'(bus.out_ctrl),
              69'(qc.pop_front()));
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        qd.push_back(curD);
        qc.push_back(curC);
        sent++;
        curD = {$urandom, $urandom, 5'($urandom)};
        curC = 4'($urandom);
      end
    end
    chk("sb.received", 69'(got), 69'd100);
    bus.in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter CTRL_W, default 4, meaning control-field width (RegWrite, ResultSrc, MemWrite, MemType); zeroed on bubble or flush.
REQ-002 SHALL have parameter DATA_W, default 69, meaning payload width (ALUResult 32 + WriteData 32 + Rd 5); never zeroed except by reset.
REQ-003 SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-004 SHALL have one clock and asynchronous active-high reset: clk  input  1  clock; rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  upstream stage holds a valid instruction.
REQ-006 in_ready  output  1  stage can accept this cycle.
REQ-007 in_ctrl  input  CTRL_W  upstream control fields.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 out_valid  output  1  downstream sees a valid instruction.
REQ-010 out_ready  input  1  downstream accepts this cycle.
REQ-011 out_ctrl  output  CTRL_W  control to next stage.
REQ-012 out_data  output  DATA_W  payload to next stage.
REQ-013 flush  input  1  kill all held and incoming instructions.
REQ-014 occ  output  2  entries held (0..2).
REQ-015 stall_cnt  output  CNT_W  saturating count of back-pressured cycles.

Function
REQ-016 All state SHALL update on the falling edge of clk, matching the team's pipeline-register timing.
REQ-017 Transfers SHALL be in_fire = in_valid & in_ready and out_fire = out_valid & out_ready, sampled at the same edge.
REQ-018 Storage SHALL be two slots: main (drives outputs) and skid; FSM states EMPTY (occ 0), BUSY (occ 1, main valid), FULL (occ 2, both valid).
REQ-019 EMPTY: in_fire -> main<=in, BUSY; else stay.
REQ-020 BUSY: in_fire & out_fire -> main<=in, BUSY; in_fire & !out_ready -> skid<=in, FULL; out_fire & !in_valid -> EMPTY; neither -> hold.
REQ-021 FULL: out_fire -> main<=skid, BUSY; else hold; no input accepted.
REQ-022 in_ready SHALL be 1 in EMPTY/BUSY and 0 in FULL; it depends on registered state only (no out_ready-to-in_ready combinational path).
REQ-023 out_valid SHALL be 1 when state != EMPTY; out_data SHALL equal main data.
REQ-024 out_ctrl SHALL be main ctrl when out_valid, else all-zero (bubble never writes regfile or memory).
REQ-025 Latency SHALL be one falling edge from in_fire to out_valid when the stage is empty or draining.
REQ-026 flush SHALL take priority over all transitions: next edge state EMPTY, both ctrl fields cleared, in_valid that cycle discarded, data fields retained.
REQ-027 stall_cnt SHALL increment by 1 each edge with out_valid & !out_ready & !flush, saturate at 2^CNT_W-1, and never wrap.
REQ-028 Ordering SHALL be strict FIFO; no instruction duplicated or lost except by flush.

Reset
REQ-029 While rst is asserted: state EMPTY, occ 0, out_valid 0, out_ctrl 0, out_data 0, skid contents 0, stall_cnt 0, in_ready 0.
REQ-030 Reset assertion SHALL take effect immediately (asynchronously), including mid-transfer; deassertion SHALL be synchronised to the next falling edge; in_ready 1 thereafter.

Structure
REQ-031 Package pipe_pkg SHALL hold the state enum (EMPTY, BUSY, FULL) and default CTRL_W/DATA_W/CNT_W constants.
REQ-032 One sub-module pipe_slot (valid + ctrl + data register with load and clear inputs) SHALL be instantiated twice (main, skid).

Verification
REQ-033 Reset, then in_valid=1, in_ctrl=4'b1011, in_data=0x1, out_ready=1 -> one edge later out_valid=1, out_ctrl=4'b1011, occ=1.
REQ-034 out_ready=0, send A=0x10 then B=0x20 -> occ=2, in_ready=0, C=0x30 not accepted; raise out_ready -> A, B, C emerge in order, none lost.
REQ-035 FULL with out_ready=0, pulse flush with in_valid=1 -> next edge occ=0, out_valid=0, out_ctrl=0, flushed input never appears.
REQ-036 CNT_W=4, hold out_valid=1 and out_ready=0 for 20 edges -> stall_cnt=15 and stays 15.
REQ-037 Assert rst asynchronously between edges while occ=2 -> out_valid, out_ctrl, occ, stall_cnt go 0 immediately, without a clock edge.
REQ-038 Streaming 100 random items with random out_ready -> scoreboard matches order and payload; out_ctrl=0 whenever out_valid=0.
